hit_ctrl: RTL

- Produces the `hit_cat` / `hit_dog` damage pulses consumed by the health-bar block.
- Once per frame, samples both characters' and both projectiles' positions and checks bounding-box overlap.
- Enforces an invulnerability window after each hit and latches game-over from the HP values returned by the health-bar block.
- Sits between the game-logic/projectile blocks and the drawing pipeline.

---
 rtl/game_pkg.sv | 27 ++
 rtl/aabb_overlap.sv | 33 +++
 rtl/hit_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game constants and enums for the collision/damage path.
package game_pkg;

  localparam int COORD_W    = 11;
  localparam int CHAR_W     = 64;
  localparam int CHAR_H     = 64;
  localparam int PROJ_W     = 16;
  localparam int PROJ_H     = 16;
  localparam int HEALTH_MAX = 500;
  localparam int DAMAGE     = 50;
  localparam int HP_W       = 10;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_CAT  = 2'b01,
    WIN_DOG  = 2'b10,
    WIN_DRAW = 2'b11
  } winner_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_ISSUE  = 2'd3
  } hit_state_t;

endpackage

// File: rtl/aabb_overlap.sv
// Combinational axis-aligned box overlap; edge-touching boxes do not overlap.
module aabb_overlap
  import game_pkg::*;
#(
  parameter int AW = PROJ_W,
  parameter int AH = PROJ_H,
  parameter int BW = CHAR_W,
  parameter int BH = CHAR_H
) (
  input  logic [COORD_W-1:0] ax,
  input  logic [COORD_W-1:0] ay,
  input  logic [COORD_W-1:0] bx,
  input  logic [COORD_W-1:0] by,
  output logic               overlap
);

  localparam logic [COORD_W:0] AW_E = (COORD_W+1)'(AW);
  localparam logic [COORD_W:0] AH_E = (COORD_W+1)'(AH);
  localparam logic [COORD_W:0] BW_E = (COORD_W+1)'(BW);
  localparam logic [COORD_W:0] BH_E = (COORD_W+1)'(BH);

  // One extra bit keeps sums near the screen edge from wrapping.
  logic [COORD_W:0] ax_e, ay_e, bx_e, by_e;

  assign ax_e = {1'b0, ax};
  assign ay_e = {1'b0, ay};
  assign bx_e = {1'b0, bx};
  assign by_e = {1'b0, by};

  assign overlap = (ax_e < bx_e + BW_E) && (bx_e < ax_e + AW_E) &&
                   (ay_e < by_e + BH_E) && (by_e < ay_e + AH_E);

endmodule

// File: rtl/hit_ctrl.sv
// Per-frame projectile/character collision check, damage pulses,
// invulnerability cooldowns and sticky game-over/winner latch.
module hit_ctrl
  import game_pkg::*;
#(
  parameter int CHAR_W        = game_pkg::CHAR_W,
  parameter int CHAR_H        = game_pkg::CHAR_H,
  parameter int PROJ_W        = game_pkg::PROJ_W,
  parameter int PROJ_H        = game_pkg::PROJ_H,
  parameter int INVULN_FRAMES = 30
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_tick,
  input  logic [COORD_W-1:0]  cat_x,
  input  logic [COORD_W-1:0]  cat_y,
  input  logic [COORD_W-1:0]  dog_x,
  input  logic [COORD_W-1:0]  dog_y,
  input  logic                cat_proj_valid,
  input  logic [COORD_W-1:0]  cat_proj_x,
  input  logic [COORD_W-1:0]  cat_proj_y,
  input  logic                dog_proj_valid,
  input  logic [COORD_W-1:0]  dog_proj_x,
  input  logic [COORD_W-1:0]  dog_proj_y,
  input  logic [HP_W-1:0]     hp_cat,
  input  logic [HP_W-1:0]     hp_dog,
  output logic                hit_cat,
  output logic                hit_dog,
  output logic                cat_proj_clear,
  output logic                dog_proj_clear,
  output logic                game_over,
  output logic [1:0]          winner,
  output logic                busy
);

  // state     | meaning
  // ST_IDLE   | waiting for frame_tick; inputs captured on the tick
  // ST_SAMPLE | cooldown decrement, game-over evaluation
  // ST_CHECK  | overlap results registered
  // ST_ISSUE  | one-cycle hit/clear pulses, cooldown reload

  localparam logic [5:0] CD_LOAD = 6'(INVULN_FRAMES);

  hit_state_t state, state_nxt;

  logic [COORD_W-1:0] s_cat_x, s_cat_y, s_dog_x, s_dog_y;
  logic [COORD_W-1:0] s_cp_x, s_cp_y, s_dp_x, s_dp_y;
  logic               s_cp_valid, s_dp_valid;
  logic [HP_W-1:0]    s_hp_cat, s_hp_dog;
  logic [5:0]         cd_cat, cd_dog;
  logic               ov_cat, ov_dog;
  logic               ov_cat_c, ov_dog_c;
  logic               go;
  winner_t            win;

  aabb_overlap #(.AW(PROJ_W), .AH(PROJ_H), .BW(CHAR_W), .BH(CHAR_H)) u_ov_dog (
    .ax(s_cp_x), .ay(s_cp_y), .bx(s_dog_x), .by(s_dog_y), .overlap(ov_dog_c)
  );

  aabb_overlap #(.AW(PROJ_W), .AH(PROJ_H), .BW(CHAR_W), .BH(CHAR_H)) u_ov_cat (
    .ax(s_dp_x), .ay(s_dp_y), .bx(s_cat_x), .by(s_cat_y), .overlap(ov_cat_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (frame_tick) state_nxt = ST_SAMPLE;
      ST_SAMPLE: state_nxt = ST_CHECK;
      ST_CHECK:  state_nxt = ST_ISSUE;
      ST_ISSUE:  state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    hit_cat        = 1'b0;
    hit_dog        = 1'b0;
    cat_proj_clear = 1'b0;
    dog_proj_clear = 1'b0;
    if (state == ST_ISSUE && !go) begin
      hit_dog        = ov_dog && (cd_dog == 6'd0);
      hit_cat        = ov_cat && (cd_cat == 6'd0);
      cat_proj_clear = ov_dog;
      dog_proj_clear = ov_cat;
    end
  end

  assign busy      = (state != ST_IDLE);
  assign game_over = go;
  assign winner    = win;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_cat_x    <= '0;
      s_cat_y    <= '0;
      s_dog_x    <= '0;
      s_dog_y    <= '0;
      s_cp_x     <= '0;
      s_cp_y     <= '0;
      s_dp_x     <= '0;
      s_dp_y     <= '0;
      s_cp_valid <= 1'b0;
      s_dp_valid <= 1'b0;
      s_hp_cat   <= '0;
      s_hp_dog   <= '0;
      cd_cat     <= '0;
      cd_dog     <= '0;
      ov_cat     <= 1'b0;
      ov_dog     <= 1'b0;
      go         <= 1'b0;
      win        <= WIN_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_tick) begin
            s_cat_x    <= cat_x;
            s_cat_y    <= cat_y;
            s_dog_x    <= dog_x;
            s_dog_y    <= dog_y;
            s_cp_x     <= cat_proj_x;
            s_cp_y     <= cat_proj_y;
            s_dp_x     <= dog_proj_x;
            s_dp_y     <= dog_proj_y;
            s_cp_valid <= cat_proj_valid;
            s_dp_valid <= dog_proj_valid;
            s_hp_cat   <= hp_cat;
            s_hp_dog   <= hp_dog;
          end
        end
        ST_SAMPLE: begin
          if (cd_cat != 6'd0) cd_cat <= cd_cat - 6'd1;
          if (cd_dog != 6'd0) cd_dog <= cd_dog - 6'd1;
          // A dead dog means cat wins (01), a dead cat means dog wins (10).
          if (!go && (s_hp_cat == '0 || s_hp_dog == '0)) begin
            go  <= 1'b1;
            win <= winner_t'({s_hp_cat == '0, s_hp_dog == '0});
          end
        end
        ST_CHECK: begin
          ov_dog <= s_cp_valid && ov_dog_c;
          ov_cat <= s_dp_valid && ov_cat_c;
        end
        ST_ISSUE: begin
          if (hit_dog) cd_dog <= CD_LOAD;
          if (hit_cat) cd_cat <= CD_LOAD;
        end
        default: ;
      endcase
    end
  end

endmodule
